mano_basic_cpu: RTL and testbench
=================================

Name: mano_basic_cpu

Overview:
- Accumulator-based 16-bit processor in the Mano "basic computer" style: 4096x16 unified memory, common 16-bit bus, hardwired control unit driven by a 4-bit sequence counter.
- Executes memory-reference, register-reference and I/O instructions.
- Exposes every register, the bus, the ALU result and the 29-bit control word for bench visibility.

Parameters:
- MEM_INIT, "" : hex file loaded into memory at time zero. Empty string means all memory words are 0.
- ADDR_W, 12 : address width. Memory depth is 2**ADDR_W.

Ports:
- clk  in  1  : system clock; all state updates on the rising edge.
- rst  in  1  : asynchronous, active-low reset.
- inpt  in  8  : external input device data.
- S  out  1  : start/run flip-flop.
- control_word  out  29  : current decoded control signals (combinational).
- instruction  out  16  : copy of IR.
- Time  out  4  : sequence counter value (T index).
- mem_out  out  16  : M[AR], asynchronous read.
- dout_IR, dout_TR, dout_DR, dout_AC  out  16 each  : register contents.
- dout_PC, dout_AR  out  12 each  : register contents.
- dout_INPR, dout_OUTR  out  8 each  : register contents.
- bus_data  out  16  : common bus value.
- alu_result  out  16  : ALU output.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- While rst=0, all registers, E, IEN and SC are 0, and S=1.
- Memory contents are unaffected by reset.
- INPR loads inpt on every clock edge.
- FGI and FGO are tied to 1. There is no interrupt cycle.
- When S=0: no register or memory update occurs, Time is frozen, and INPR still loads.
- When S=1: SC increments every cycle unless SC_clr is asserted, in which case SC goes to 0.
- control_word bit map:
  - [2:0] bus_sel: 0 = zero, 1 = AR (zero-extended), 2 = PC (zero-extended), 3 = DR, 4 = AC, 5 = IR, 6 = TR, 7 = memory.
  - AR: [3] ld, [4] inc, [5] clr.
  - PC: [6] ld, [7] inc, [8] clr.
  - DR: [9] ld, [10] inc.
  - AC: [11] ld from ALU, [12] inc, [13] clr.
  - [14] IR_ld; [15] TR_ld; [16] TR_inc.
  - [17] OUTR_ld (loads bus[7:0]); [18] mem_write (writes bus into M[AR] on the clock edge).
  - [21:19] alu_op: 0 = AND, 1 = ADD, 2 = DR, 3 = INPR, 4 = CMA, 5 = CIR, 6 = CIL, 7 = AC.
  - [22] E_clr; [23] E_cmp; [24] SC_clr; [25] S_clr.
  - [26] IEN_set; [27] IEN_clr; [28] reserved, always 0.
- ALU:
  - ADD: {E,AC} <= AC + DR, 17-bit sum; carry-out goes to E.
  - CIR / CIL: rotate through E.
  - alu_result is valid every cycle.
  - E updates only on ADD, CIR, CIL, E_clr and E_cmp.
- Fetch and decode:
  - T0: AR <= PC.
  - T1: IR <= M[AR]; PC <= PC+1.
  - T2: AR <= IR[11:0]; I <= IR[15].
- T3 by instruction type:
  - Memory-reference with I=1: AR <= M[AR].
  - Memory-reference with I=0: no operation.
  - Register-reference / I/O (opcode 111): execute, then SC_clr.
- Memory-reference execution, opcode 000..110:
  - AND: T4 DR <= M; T5 AC <= AC&DR, SC_clr.
  - ADD: T4 DR <= M; T5 {E,AC} <= AC+DR, SC_clr.
  - LDA: T4 DR <= M; T5 AC <= DR, SC_clr.
  - STA: T4 M <= AC, SC_clr.
  - BUN: T4 PC <= AR, SC_clr.
  - BSA: T4 M <= PC (bus), AR <= AR+1; T5 PC <= AR, SC_clr.
  - ISZ: T4 DR <= M; T5 DR <= DR+1; T6 M <= DR; if DR == 0 then PC <= PC+1; SC_clr.
- Register-reference, I=0, IR[11:0] one-hot:
  - 800 CLA, 400 CLE, 200 CMA, 100 CME, 080 CIR, 040 CIL, 020 INC.
  - 010 SPA, 008 SNA, 004 SZA, 002 SZE: skip by PC+1 when the condition holds.
  - 001 HLT: S <= 0.
- I/O, I=1, IR[11:0]:
  - 800 INP: AC <= {8'h00, INPR}.
  - 400 OUT: OUTR <= AC[7:0].
  - 200 SKI, 100 SKO: always skip.
  - 080 ION: IEN <= 1. 040 IOF: IEN <= 0.
- Wrap-around: PC and AR wrap modulo 4096. AC increment wraps from FFFF to 0000.
- Reset asserted mid-instruction aborts the instruction immediately. Memory writes already performed remain.

Decomposition:
- Package mano_pkg holds:
  - control-word bit index constants;
  - bus_sel and alu_op encodings;
  - opcode and register-reference/I/O code constants.
- One natural sub-module: mano_alu. It is combinational: AC, DR, INPR, E, alu_op in; result and E_next out.

Test Plan:
- Reset: rst=0 -> all dout_* = 0, Time = 0, S = 1. After release, Time counts 0,1,2,3 and T1 loads IR from M[0].
- Program LDA 010 / ADD 011 / STA 012 / HLT, with M[010]=7FFF and M[011]=0001 -> M[012]=8000, E=0, S=0, and Time freezes.
- ADD with FFFF+0001 -> AC=0000, E=1. Follow with CIL -> AC=0001, E=0.
- Indirect BUN: I=1 through a pointer word -> PC equals the pointed address. ISZ on FFFF -> word becomes 0000 and the next instruction is skipped.
- INP with inpt=8'hA5 -> AC=00A5. OUT -> dout_OUTR=A5. SZA with AC nonzero -> no skip.
- Reset pulse during T5 of ADD -> registers return to 0, and fetch restarts from PC=0 after release.

Source files
------------

// File: rtl/mano_pkg.sv
// mano_pkg: shared constants for the Mano basic computer.
//   - bit positions inside the 29-bit control word
//   - bus source and ALU operation encodings
//   - memory-reference opcodes and register-reference / I/O codes
//   - has_code(): tests whether an IR[11:0] field selects a given one-hot code
package mano_pkg;

   localparam int CW_W = 29;

   // Control word bit map. Bit 28 is reserved and always 0.
   localparam int CW_BUS      = 0;   // [2:0] bus source
   localparam int CW_AR_LD    = 3;
   localparam int CW_AR_INC   = 4;
   localparam int CW_AR_CLR   = 5;
   localparam int CW_PC_LD    = 6;
   localparam int CW_PC_INC   = 7;
   localparam int CW_PC_CLR   = 8;
   localparam int CW_DR_LD    = 9;
   localparam int CW_DR_INC   = 10;
   localparam int CW_AC_LD    = 11;
   localparam int CW_AC_INC   = 12;
   localparam int CW_AC_CLR   = 13;
   localparam int CW_IR_LD    = 14;
   localparam int CW_TR_LD    = 15;
   localparam int CW_TR_INC   = 16;
   localparam int CW_OUTR_LD  = 17;
   localparam int CW_MEM_WR   = 18;
   localparam int CW_ALU      = 19;  // [21:19] ALU operation
   localparam int CW_E_CLR    = 22;
   localparam int CW_E_CMP    = 23;
   localparam int CW_SC_CLR   = 24;
   localparam int CW_S_CLR    = 25;
   localparam int CW_IEN_SET  = 26;
   localparam int CW_IEN_CLR  = 27;

   // Bus sources
   localparam logic [2:0] BUS_ZERO = 3'd0;
   localparam logic [2:0] BUS_AR   = 3'd1;
   localparam logic [2:0] BUS_PC   = 3'd2;
   localparam logic [2:0] BUS_DR   = 3'd3;
   localparam logic [2:0] BUS_AC   = 3'd4;
   localparam logic [2:0] BUS_IR   = 3'd5;
   localparam logic [2:0] BUS_TR   = 3'd6;
   localparam logic [2:0] BUS_MEM  = 3'd7;

   // ALU operations
   localparam logic [2:0] ALU_AND  = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_DR   = 3'd2;
   localparam logic [2:0] ALU_INPR = 3'd3;
   localparam logic [2:0] ALU_CMA  = 3'd4;
   localparam logic [2:0] ALU_CIR  = 3'd5;
   localparam logic [2:0] ALU_CIL  = 3'd6;
   localparam logic [2:0] ALU_AC   = 3'd7;

   // Opcodes IR[14:12]; 111 selects register-reference / I/O
   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_RIO = 3'd7;

   // Register-reference codes (I=0)
   localparam logic [11:0] RR_CLA = 12'h800;
   localparam logic [11:0] RR_CLE = 12'h400;
   localparam logic [11:0] RR_CMA = 12'h200;
   localparam logic [11:0] RR_CME = 12'h100;
   localparam logic [11:0] RR_CIR = 12'h080;
   localparam logic [11:0] RR_CIL = 12'h040;
   localparam logic [11:0] RR_INC = 12'h020;
   localparam logic [11:0] RR_SPA = 12'h010;
   localparam logic [11:0] RR_SNA = 12'h008;
   localparam logic [11:0] RR_SZA = 12'h004;
   localparam logic [11:0] RR_SZE = 12'h002;
   localparam logic [11:0] RR_HLT = 12'h001;

   // I/O codes (I=1)
   localparam logic [11:0] IO_INP = 12'h800;
   localparam logic [11:0] IO_OUT = 12'h400;
   localparam logic [11:0] IO_SKI = 12'h200;
   localparam logic [11:0] IO_SKO = 12'h100;
   localparam logic [11:0] IO_ION = 12'h080;
   localparam logic [11:0] IO_IOF = 12'h040;

   function automatic logic has_code(input logic [11:0] field, input logic [11:0] code);
      return |(field & code);
   endfunction

endpackage

// File: rtl/mano_basic_cpu_alu.sv
// mano_alu: combinational accumulator logic unit.
//   ac, dr, inpr, e, alu_op in; result (next AC value) and e_next out.
//   e_next differs from e only for ADD (carry-out) and the rotates.
module mano_alu
   import mano_pkg::*;
(
   input  logic [15:0] ac,
   input  logic [15:0] dr,
   input  logic [7:0]  inpr,
   input  logic        e,
   input  logic [2:0]  alu_op,
   output logic [15:0] result,
   output logic        e_next
);

   logic [16:0] sum;

   assign sum = {1'b0, ac} + {1'b0, dr};

   always_comb begin
      result = ac;
      e_next = e;
      case (alu_op)
         ALU_AND:  result = ac & dr;
         ALU_ADD:  begin
            result = sum[15:0];
            e_next = sum[16];
         end
         ALU_DR:   result = dr;
         ALU_INPR: result = {8'h00, inpr};
         ALU_CMA:  result = ~ac;
         // Rotates run through E: the bit shifted out lands in E.
         ALU_CIR:  begin
            result = {e, ac[15:1]};
            e_next = ac[0];
         end
         ALU_CIL:  begin
            result = {ac[14:0], e};
            e_next = ac[15];
         end
         ALU_AC:   result = ac;
         default:  result = ac;
      endcase
   end

endmodule

// File: rtl/mano_basic_cpu.sv
// mano_basic_cpu: 16-bit accumulator machine in the Mano basic-computer style.
//   clk, rst (async, active-low), inpt[7:0] external input byte.
//   S run flag, control_word[28:0] decoded controls, instruction (IR copy),
//   Time (sequence counter), mem_out = M[AR], dout_* register contents,
//   bus_data common bus, alu_result ALU output.
// A 4-bit sequence counter steps T0..T6; every instruction ends by clearing it.
// The sequence counter is the only control state and is visible on Time.
module mano_basic_cpu
  import mano_pkg::*;
#(
  parameter string MEM_INIT = "",
  parameter int    ADDR_W   = 12
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        inpt,
  output logic              S,
  output logic [CW_W-1:0]   control_word,
  output logic [15:0]       instruction,
  output logic [3:0]        Time,
  output logic [15:0]       mem_out,
  output logic [15:0]       dout_IR,
  output logic [15:0]       dout_TR,
  output logic [15:0]       dout_DR,
  output logic [15:0]       dout_AC,
  output logic [ADDR_W-1:0] dout_PC,
  output logic [ADDR_W-1:0] dout_AR,
  output logic [7:0]        dout_INPR,
  output logic [7:0]        dout_OUTR,
  output logic [15:0]       bus_data,
  output logic [15:0]       alu_result
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  // No flag hardware exists: the device is always ready.
  localparam logic              FGI      = 1'b1;
  localparam logic              FGO      = 1'b1;

  logic [15:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] ar, pc;
  logic [15:0]       ir, tr, dr, ac;
  logic [7:0]        inpr, outr;
  logic              e, i_ff, ien, s;
  logic [3:0]        sc;
  logic [CW_W-1:0]   cw;
  logic [15:0]       bus, mem_rd, alu_res;
  logic              e_next, e_from_alu;
  logic [2:0]        opcode, alu_op;
  logic              t0, t1, t2, t3, t4, t5, t6, d7;
  logic              unused_ien;

  assign opcode = ir[14:12];
  assign d7     = (opcode == OP_RIO);
  assign t0     = (sc == 4'd0);
  assign t1     = (sc == 4'd1);
  assign t2     = (sc == 4'd2);
  assign t3     = (sc == 4'd3);
  assign t4     = (sc == 4'd4);
  assign t5     = (sc == 4'd5);
  assign t6     = (sc == 4'd6);
  assign mem_rd = mem[ar];
  assign alu_op = cw[CW_ALU +: 3];

  // IEN is programmer-visible state with no consumer while there is no interrupt cycle.
  assign unused_ien = ien;

  // ---------------- hardwired control ----------------
  always_comb begin
    cw = '0;
    if (t0) begin
      cw[CW_BUS +: 3] = BUS_PC;
      cw[CW_AR_LD]    = 1'b1;
    end else if (t1) begin
      cw[CW_BUS +: 3] = BUS_MEM;
      cw[CW_IR_LD]    = 1'b1;
      cw[CW_PC_INC]   = 1'b1;
    end else if (t2) begin
      cw[CW_BUS +: 3] = BUS_IR;
      cw[CW_AR_LD]    = 1'b1;
    end else if (t3 && d7) begin
      cw[CW_SC_CLR] = 1'b1;
      if (!i_ff) begin
        if (has_code(ir[11:0], RR_CLA)) cw[CW_AC_CLR] = 1'b1;
        if (has_code(ir[11:0], RR_CLE)) cw[CW_E_CLR]  = 1'b1;
        if (has_code(ir[11:0], RR_CMA)) begin
          cw[CW_AC_LD]    = 1'b1;
          cw[CW_ALU +: 3] = ALU_CMA;
        end
        if (has_code(ir[11:0], RR_CME)) cw[CW_E_CMP]  = 1'b1;
        if (has_code(ir[11:0], RR_CIR)) begin
          cw[CW_AC_LD]    = 1'b1;
          cw[CW_ALU +: 3] = ALU_CIR;
        end
        if (has_code(ir[11:0], RR_CIL)) begin
          cw[CW_AC_LD]    = 1'b1;
          cw[CW_ALU +: 3] = ALU_CIL;
        end
        if (has_code(ir[11:0], RR_INC)) cw[CW_AC_INC] = 1'b1;
        if ((has_code(ir[11:0], RR_SPA) && !ac[15]) ||
            (has_code(ir[11:0], RR_SNA) &&  ac[15]) ||
            (has_code(ir[11:0], RR_SZA) && (ac == 16'h0000)) ||
            (has_code(ir[11:0], RR_SZE) && !e))
          cw[CW_PC_INC] = 1'b1;
        if (has_code(ir[11:0], RR_HLT)) cw[CW_S_CLR] = 1'b1;
      end else begin
        if (has_code(ir[11:0], IO_INP)) begin
          cw[CW_AC_LD]    = 1'b1;
          cw[CW_ALU +: 3] = ALU_INPR;
        end
        if (has_code(ir[11:0], IO_OUT)) begin
          cw[CW_BUS +: 3] = BUS_AC;
          cw[CW_OUTR_LD]  = 1'b1;
        end
        if ((has_code(ir[11:0], IO_SKI) && FGI) ||
            (has_code(ir[11:0], IO_SKO) && FGO))
          cw[CW_PC_INC] = 1'b1;
        if (has_code(ir[11:0], IO_ION)) cw[CW_IEN_SET] = 1'b1;
        if (has_code(ir[11:0], IO_IOF)) cw[CW_IEN_CLR] = 1'b1;
      end
    end else if (t3) begin
      // Indirect memory reference: the operand address is fetched from M[AR].
      if (i_ff) begin
        cw[CW_BUS +: 3] = BUS_MEM;
        cw[CW_AR_LD]    = 1'b1;
      end
    end else if (!d7) begin
      case (opcode)
        OP_AND, OP_ADD, OP_LDA: begin
          if (t4) begin
            cw[CW_BUS +: 3] = BUS_MEM;
            cw[CW_DR_LD]    = 1'b1;
          end else if (t5) begin
            cw[CW_AC_LD]  = 1'b1;
            cw[CW_SC_CLR] = 1'b1;
            if (opcode == OP_AND)      cw[CW_ALU +: 3] = ALU_AND;
            else if (opcode == OP_ADD) cw[CW_ALU +: 3] = ALU_ADD;
            else                       cw[CW_ALU +: 3] = ALU_DR;
          end
        end
        OP_STA: begin
          if (t4) begin
            cw[CW_BUS +: 3] = BUS_AC;
            cw[CW_MEM_WR]   = 1'b1;
            cw[CW_SC_CLR]   = 1'b1;
          end
        end
        OP_BUN: begin
          if (t4) begin
            cw[CW_BUS +: 3] = BUS_AR;
            cw[CW_PC_LD]    = 1'b1;
            cw[CW_SC_CLR]   = 1'b1;
          end
        end
        OP_BSA: begin
          // Return address is written at the old AR while AR steps past it.
          if (t4) begin
            cw[CW_BUS +: 3] = BUS_PC;
            cw[CW_MEM_WR]   = 1'b1;
            cw[CW_AR_INC]   = 1'b1;
          end else if (t5) begin
            cw[CW_BUS +: 3] = BUS_AR;
            cw[CW_PC_LD]    = 1'b1;
            cw[CW_SC_CLR]   = 1'b1;
          end
        end
        OP_ISZ: begin
          if (t4) begin
            cw[CW_BUS +: 3] = BUS_MEM;
            cw[CW_DR_LD]    = 1'b1;
          end else if (t5) begin
            cw[CW_DR_INC] = 1'b1;
          end else if (t6) begin
            cw[CW_BUS +: 3] = BUS_DR;
            cw[CW_MEM_WR]   = 1'b1;
            cw[CW_SC_CLR]   = 1'b1;
            if (dr == 16'h0000) cw[CW_PC_INC] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- common bus ----------------
  always_comb begin
    case (cw[CW_BUS +: 3])
      BUS_ZERO: bus = 16'h0000;
      BUS_AR:   bus = {{(16-ADDR_W){1'b0}}, ar};
      BUS_PC:   bus = {{(16-ADDR_W){1'b0}}, pc};
      BUS_DR:   bus = dr;
      BUS_AC:   bus = ac;
      BUS_IR:   bus = ir;
      BUS_TR:   bus = tr;
      BUS_MEM:  bus = mem_rd;
      default:  bus = 16'h0000;
    endcase
  end

  mano_alu u_alu (
    .ac     (ac),
    .dr     (dr),
    .inpr   (inpr),
    .e      (e),
    .alu_op (alu_op),
    .result (alu_res),
    .e_next (e_next)
  );

  assign e_from_alu = cw[CW_AC_LD] &&
                      ((alu_op == ALU_ADD) || (alu_op == ALU_CIR) || (alu_op == ALU_CIL));

  // ---------------- registers ----------------
  // INPR samples the device every edge, even when halted; everything else waits on S.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar   <= '0;
      pc   <= '0;
      dr   <= '0;
      ac   <= '0;
      ir   <= '0;
      tr   <= '0;
      inpr <= '0;
      outr <= '0;
      e    <= 1'b0;
      i_ff <= 1'b0;
      ien  <= 1'b0;
      s    <= 1'b1;
      sc   <= '0;
    end else begin
      inpr <= inpt;
      if (s) begin
        if (cw[CW_AR_CLR])      ar <= '0;
        else if (cw[CW_AR_LD])  ar <= bus[ADDR_W-1:0];
        else if (cw[CW_AR_INC]) ar <= ar + ADDR_ONE;

        if (cw[CW_PC_CLR])      pc <= '0;
        else if (cw[CW_PC_LD])  pc <= bus[ADDR_W-1:0];
        else if (cw[CW_PC_INC]) pc <= pc + ADDR_ONE;

        if (cw[CW_DR_LD])       dr <= bus;
        else if (cw[CW_DR_INC]) dr <= dr + 16'd1;

        if (cw[CW_AC_CLR])      ac <= '0;
        else if (cw[CW_AC_LD])  ac <= alu_res;
        else if (cw[CW_AC_INC]) ac <= ac + 16'd1;

        if (cw[CW_IR_LD])       ir <= bus;

        if (cw[CW_TR_LD])       tr <= bus;
        else if (cw[CW_TR_INC]) tr <= tr + 16'd1;

        if (cw[CW_OUTR_LD])     outr <= bus[7:0];

        if (cw[CW_E_CLR])       e <= 1'b0;
        else if (cw[CW_E_CMP])  e <= ~e;
        else if (e_from_alu)    e <= e_next;

        if (t2)                 i_ff <= ir[15];

        if (cw[CW_IEN_SET])      ien <= 1'b1;
        else if (cw[CW_IEN_CLR]) ien <= 1'b0;

        if (cw[CW_S_CLR])       s <= 1'b0;

        sc <= cw[CW_SC_CLR] ? 4'd0 : sc + 4'd1;
      end
    end
  end

  // Memory has no reset: contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (s && cw[CW_MEM_WR]) mem[ar] <= bus;
  end

  assign S            = s;
  assign control_word = cw;
  assign instruction  = ir;
  assign Time         = sc;
  assign mem_out      = mem_rd;
  assign dout_IR      = ir;
  assign dout_TR      = tr;
  assign dout_DR      = dr;
  assign dout_AC      = ac;
  assign dout_PC      = pc;
  assign dout_AR      = ar;
  assign dout_INPR    = inpr;
  assign dout_OUTR    = outr;
  assign bus_data     = bus;
  assign alu_result   = alu_res;

endmodule

// File: tb/tb_mano_basic_cpu.sv
// tb_mano_basic_cpu: directed programs for mano_basic_cpu.
// Programs are placed in memory while the CPU is held in reset, then run to HLT.
module tb_mano_basic_cpu;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  inpt;
   logic        S;
   logic [28:0] control_word;
   logic [15:0] instruction;
   logic [3:0]  Time;
   logic [15:0] mem_out;
   logic [15:0] dout_IR, dout_TR, dout_DR, dout_AC;
   logic [11:0] dout_PC, dout_AR;
   logic [7:0]  dout_INPR, dout_OUTR;
   logic [15:0] bus_data, alu_result;

   int vectors     = 0;
   int miscompares = 0;

   mano_basic_cpu dut (
      .clk          (clk),
      .rst          (rst),
      .inpt         (inpt),
      .S            (S),
      .control_word (control_word),
      .instruction  (instruction),
      .Time         (Time),
      .mem_out      (mem_out),
      .dout_IR      (dout_IR),
      .dout_TR      (dout_TR),
      .dout_DR      (dout_DR),
      .dout_AC      (dout_AC),
      .dout_PC      (dout_PC),
      .dout_AR      (dout_AR),
      .dout_INPR    (dout_INPR),
      .dout_OUTR    (dout_OUTR),
      .bus_data     (bus_data),
      .alu_result   (alu_result)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic poke(input int addr, input logic [15:0] data);
      dut.mem[addr] <= data;
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 128; a++) dut.mem[a] <= 16'h0000;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [3:0] t, input logic [15:0] ir_val, input string tag);
      int n = 0;
      while (!(Time === t && instruction === ir_val) && n < 400) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      assert (n < 400) else begin
         miscompares++;
         $error("FAIL %s: T%0d with IR=%h not reached, observed T%0d IR=%h", tag, t, ir_val, Time, instruction);
      end
   endtask

   task automatic run_halt(input string tag);
      int n = 0;
      while (S === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      assert (n < 400) else begin
         miscompares++;
         $error("FAIL %s: no halt after %0d cycles, S observed %b expected 0", tag, n, S);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst  = 1'b0;
      inpt = 8'h5A;

      // Program A: LDA 010 / ADD 011 / STA 012 / HLT
      clear_mem();
      poke(12'h000, 16'h2010);
      poke(12'h001, 16'h1011);
      poke(12'h002, 16'h3012);
      poke(12'h003, 16'h7001);
      poke(12'h010, 16'h7FFF);
      poke(12'h011, 16'h0001);
      repeat (3) @(negedge clk);

      check("rst_ac",   dout_AC,   16'h0000);
      check("rst_dr",   dout_DR,   16'h0000);
      check("rst_ir",   dout_IR,   16'h0000);
      check("rst_tr",   dout_TR,   16'h0000);
      check("rst_pc",   dout_PC,   12'h000);
      check("rst_ar",   dout_AR,   12'h000);
      check("rst_inpr", dout_INPR, 8'h00);
      check("rst_outr", dout_OUTR, 8'h00);
      check("rst_e",    dut.e,     1'b0);
      check("rst_time", Time,      4'd0);
      check("rst_s",    S,         1'b1);
      check("rst_cw_t0", control_word, 29'h000000A);

      rst = 1'b1;
      @(negedge clk);
      check("a_t1_time", Time,    4'd1);
      check("a_t1_ar",   dout_AR, 12'h000);
      check("a_t1_cw",   control_word, 29'h0004087);
      @(negedge clk);
      check("a_t2_time", Time,        4'd2);
      check("a_t2_ir",   instruction, 16'h2010);
      check("a_t2_pc",   dout_PC,     12'h001);
      check("a_t2_cw",   control_word, 29'h000000D);
      @(negedge clk);
      check("a_t3_time", Time,    4'd3);
      check("a_t3_ar",   dout_AR, 12'h010);
      check("a_t3_mem",  mem_out, 16'h7FFF);

      run_halt("a_halt");
      check("a_m012",  dut.mem[12'h012], 16'h8000);
      check("a_ac",    dout_AC, 16'h8000);
      check("a_e",     dut.e,   1'b0);
      check("a_s",     S,       1'b0);
      check("a_pc",    dout_PC, 12'h004);
      check("a_time",  Time,    4'd0);
      repeat (3) @(negedge clk);
      check("a_frozen_time", Time,    4'd0);
      check("a_frozen_pc",   dout_PC, 12'h004);

      // Program B: LDA 010 / ADD 011 / CIL / HLT, FFFF + 0001
      rst = 1'b0;
      clear_mem();
      poke(12'h000, 16'h2010);
      poke(12'h001, 16'h1011);
      poke(12'h002, 16'h7040);
      poke(12'h003, 16'h7001);
      poke(12'h010, 16'hFFFF);
      poke(12'h011, 16'h0001);
      @(negedge clk);
      rst = 1'b1;
      wait_state(4'd3, 16'h7040, "b_reach_cil");
      check("b_add_ac", dout_AC, 16'h0000);
      check("b_add_e",  dut.e,   1'b1);
      run_halt("b_halt");
      check("b_cil_ac", dout_AC, 16'h0001);
      check("b_cil_e",  dut.e,   1'b0);

      // Program C: BUN I 020 -> 030: ISZ 040 (FFFF) skips 031, LDA 040, HLT
      rst = 1'b0;
      clear_mem();
      poke(12'h000, 16'hC020);
      poke(12'h020, 16'h0030);
      poke(12'h030, 16'h6040);
      poke(12'h031, 16'h7001);
      poke(12'h032, 16'h2040);
      poke(12'h033, 16'h7001);
      poke(12'h040, 16'hFFFF);
      @(negedge clk);
      rst = 1'b1;
      wait_state(4'd3, 16'hC020, "c_reach_t3");
      check("c_t3_ar", dout_AR, 12'h020);
      wait_state(4'd4, 16'hC020, "c_reach_t4");
      check("c_t4_ar", dout_AR, 12'h030);
      wait_state(4'd0, 16'hC020, "c_reach_bun_done");
      check("c_bun_pc", dout_PC, 12'h030);
      run_halt("c_halt");
      check("c_m040", dut.mem[12'h040], 16'h0000);
      check("c_pc",   dout_PC, 12'h034);
      check("c_ac",   dout_AC, 16'h0000);

      // Program D: INP / OUT / SZA (no skip) / SKI (skip) / HLT / HLT
      rst  = 1'b0;
      inpt = 8'hA5;
      clear_mem();
      poke(12'h000, 16'hF800);
      poke(12'h001, 16'hF400);
      poke(12'h002, 16'h7004);
      poke(12'h003, 16'hF200);
      poke(12'h004, 16'h7001);
      poke(12'h005, 16'h7001);
      @(negedge clk);
      rst = 1'b1;
      run_halt("d_halt");
      check("d_ac",   dout_AC,   16'h00A5);
      check("d_outr", dout_OUTR, 8'hA5);
      check("d_pc",   dout_PC,   12'h006);
      check("d_inpr", dout_INPR, 8'hA5);
      inpt = 8'h3C;
      @(negedge clk);
      check("d_inpr_halted", dout_INPR, 8'h3C);
      check("d_time_halted", Time,      4'd0);

      // Program A again, reset pulse during T5 of ADD
      rst = 1'b0;
      clear_mem();
      poke(12'h000, 16'h2010);
      poke(12'h001, 16'h1011);
      poke(12'h002, 16'h3012);
      poke(12'h003, 16'h7001);
      poke(12'h010, 16'h7FFF);
      poke(12'h011, 16'h0001);
      @(negedge clk);
      rst = 1'b1;
      wait_state(4'd5, 16'h1011, "e_reach_add_t5");
      check("e_pre_ac", dout_AC, 16'h7FFF);
      rst = 1'b0;
      #1;
      check("e_rst_ac",   dout_AC, 16'h0000);
      check("e_rst_dr",   dout_DR, 16'h0000);
      check("e_rst_ir",   dout_IR, 16'h0000);
      check("e_rst_pc",   dout_PC, 12'h000);
      check("e_rst_time", Time,    4'd0);
      check("e_rst_s",    S,       1'b1);
      check("e_rst_mem",  dut.mem[12'h010], 16'h7FFF);
      @(negedge clk);
      rst = 1'b1;
      wait_state(4'd2, 16'h2010, "e_refetch");
      check("e_refetch_pc", dout_PC, 12'h001);
      run_halt("e_halt");
      check("e_m012", dut.mem[12'h012], 16'h8000);
      check("e_pc",   dout_PC, 12'h004);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
